uart_rx: RTL and testbench

Synthesizable UART receiver that recovers 8N1-style frames from the asynchronous `uart_rx_pin` line and presents each byte on a valid/ready output. It is the FPGA-side counterpart of the bench UART transmitter. It sits between the `uart_rx_pin` pad and the test harness datapath, which drains bytes via `ready`. Frame format, bit order and sampling point match the bench receiver model: LSB first, mid-bit sampling, and stop bit(s) checked high.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing, LSB first, mid-bit sampling, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int BAUD       = 9600,
  parameter int CLK_RATE   = 12_000_000
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  uart_rx_pin,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CLKS_PER_BAUD = CLK_RATE / BAUD;
  localparam int HALF_BAUD     = CLKS_PER_BAUD / 2;
  localparam int CNT_W         = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
  localparam int IDX_W         = $clog2(DATA_WIDTH + STOP_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(CLKS_PER_BAUD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(HALF_BAUD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic                  rx_meta_q, rxs_q, rxs_prev_q;
  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  done, done_err;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    err_d       = err_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          // Shift in from the top so the first (LSB) sample lands in bit 0.
          shift_d = {rxs_q, shift_q[DATA_WIDTH-1:1]};
          if (idx_q == IDX_LAST_DATA) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_STOP;
          if (rxs_q != (^shift_q)) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (!rxs_q) err_d = 1'b1;
          if (idx_q == IDX_LAST_STOP) begin
            // Leave mid-stop-bit so an immediately following start edge is seen.
            done     = 1'b1;
            done_err = err_q | !rxs_q;
            idx_d    = '0;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (valid_q && ready) valid_d = 1'b0;
    if (done) begin
      if (done_err) begin
        frame_err_d = 1'b1;
      end else if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx_pin;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at a scaled-down baud ratio (16 clocks per bit).
// Expected events are queued by a frame-level model; a monitor pops them as the DUT reports.
module tb_uart_rx;

  localparam int DW       = 8;
  localparam int SB       = 1;
  localparam int BAUD     = 10;
  localparam int CLK_RATE = 160;
  localparam int CPB      = CLK_RATE / BAUD;
  localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LATENCY  = 2 + HALF + (DW + SB + PAR_BITS) * CPB + 1;

  localparam logic [1:0] K_DATA = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_OVR  = 2'd2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          pin = 1'b1;
  logic          ready = 1'b1;
  logic [DW-1:0] data;
  logic          valid, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [9:0]    sb[$];
  bit            model_held = 1'b0;
  logic [DW-1:0] held_byte = '0;

  uart_rx #(
    .DATA_WIDTH(DW), .STOP_BITS(SB), .BAUD(BAUD), .CLK_RATE(CLK_RATE)
  ) dut (
    .clk(clk), .n_rst(n_rst), .uart_rx_pin(pin),
    .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input logic [1:0] k);
    case (k)
      K_DATA:  return "data";
      K_FERR:  return "frame_err";
      K_OVR:   return "overrun";
      default: return "?";
    endcase
  endfunction

  function automatic void push_exp(input logic [1:0] k, input logic [DW-1:0] b);
    sb.push_back({k, b});
  endfunction

  // Frame-level outcome: bad framing -> error; otherwise delivered, held, or overrun.
  function automatic void expect_frame(input logic [DW-1:0] b, input bit ok);
    if (!ok) push_exp(K_FERR, '0);
    else if (ready) push_exp(K_DATA, b);
    else if (model_held) push_exp(K_OVR, '0);
    else begin
      model_held = 1'b1;
      held_byte  = b;
    end
  endfunction

  function automatic void check_event(input logic [1:0] k, input logic [DW-1:0] b);
    logic [9:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL event: got unexpected %s 0x%02h at cycle %0d, required none", kind_name(k), b, cyc);
    end else begin
      exp = sb.pop_front();
      if (exp !== {k, b}) begin
        errors++;
        $display("FAIL event: got %s 0x%02h at cycle %0d, required %s 0x%02h",
                 kind_name(k), b, cyc, kind_name(exp[9:8]), exp[7:0]);
      end else begin
        $display("event %s 0x%02h at cycle %0d ok", kind_name(k), b, cyc);
      end
    end
  endfunction

  task automatic check_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    pin = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input bit stop_ok, input bit par_ok, input bit predict);
    bit ok;
    ok = stop_ok && (par_ok || PAR_BITS == 0);
    if (predict) expect_frame(b, ok);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ !par_ok);
`endif
    for (int i = 0; i < SB; i++) drive_bit(stop_ok);
  endtask

  task automatic release_ready();
    @(posedge clk);
    #1;
    if (model_held) push_exp(K_DATA, held_byte);
    model_held = 1'b0;
    ready = 1'b1;
  endtask

  logic          valid_p = 1'b0;
  logic          ready_p = 1'b0;
  logic [DW-1:0] data_p = '0;

  always @(negedge clk) begin
    if (n_rst) begin
      if (valid && ready) check_event(K_DATA, data);
      if (frame_err) check_event(K_FERR, '0);
      if (overrun) check_event(K_OVR, '0);
      if (frame_err && overrun) begin
        checks++;
        errors++;
        $display("FAIL exclusive: got frame_err=1 overrun=1, required at most one");
      end
      if (valid && !valid_p) begin
        checks++;
        if ((cyc - start_cyc) < LATENCY - 1 || (cyc - start_cyc) > LATENCY + 1) begin
          errors++;
          $display("FAIL latency: got %0d cycles, required %0d +/-1", cyc - start_cyc, LATENCY);
        end
      end
      if (valid_p && !ready_p) begin
        checks++;
        if (!valid || data !== data_p) begin
          errors++;
          $display("FAIL hold: got valid=%0b data=0x%02h, required valid=1 data=0x%02h", valid, data, data_p);
        end
      end
    end
    valid_p <= valid;
    ready_p <= ready;
    data_p  <= data;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got no completion by cycle %0d, required finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("reset data", data, '0);
    check_val("reset valid", DW'(valid), '0);
    check_val("reset frame_err", DW'(frame_err), '0);
    check_val("reset overrun", DW'(overrun), '0);
    n_rst = 1'b1;
    idle_bits(2);

    // Basic patterns
    send_byte(8'h00, 1, 1, 1); idle_bits(2);
    send_byte(8'hFF, 1, 1, 1); idle_bits(2);
    send_byte(8'hA5, 1, 1, 1); idle_bits(2);

    // Back-to-back random bytes
    for (int i = 0; i < 100; i++) send_byte(8'($urandom), 1, 1, 1);
    idle_bits(2);

    // Short low glitch on idle line
    pin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_bits(3);
    send_byte(8'h3C, 1, 1, 1); idle_bits(2);

    // Stop bit low, then line held low
    send_byte(8'h55, 0, 1, 1);
    repeat (40 * CPB) @(posedge clk);
    #1;
    idle_bits(3);
    send_byte(8'h12, 1, 1, 1); idle_bits(2);

    // Consumer stalled
    ready = 1'b0;
    send_byte(8'h11, 1, 1, 1); idle_bits(1);
    send_byte(8'h22, 1, 1, 1); idle_bits(2);
    release_ready();
    idle_bits(2);

    // Reset mid-frame
    fork
      send_byte(8'h77, 1, 1, 0);
      begin
        repeat (CPB * 3 + HALF) @(posedge clk);
        #3;
        n_rst = 1'b0;
      end
    join
    idle_bits(1);
    check_val("in-reset valid", DW'(valid), '0);
    n_rst = 1'b1;
    idle_bits(2);
    send_byte(8'h88, 1, 1, 1); idle_bits(2);
    send_byte(8'h88, 1, 0, 1); idle_bits(3);

    // Random mix of good and bad framing
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom), $urandom_range(0, 3) != 0, 1, 1);
      idle_bits(3);
    end

    idle_bits(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expected events, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
